trivium_stream_core: RTL

Parametrised Trivium stream-cipher core generating W keystream bits per clock, with on-chip key/IV loading, a hardware-sequenced 1152-round warm-up, and a valid/ready data path that XORs W-bit plaintext words with keystream into a registered output stage. It supersedes the bit-serial cipher engine. It sits between the host register interface, which supplies the key, IV and start pulse, and the streaming datapath, which supplies the plaintext/ciphertext words.

---
 rtl/trivium_pkg.sv | 61 ++++++
 rtl/trivium_stream_core_round.sv | 48 ++++
 rtl/trivium_stream_core.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/trivium_pkg.sv
// ---------------------------------------------------------------------------
// trivium_pkg
//
// Shared constants and types for the Trivium stream-cipher core.
//
// Contents:
//   STATE_LEN / WARMUP_ROUNDS   - cipher state size and initialisation rounds
//   REG_A/B/C_END               - 1-based upper bounds of the three shift
//                                 registers (s1..s93, s94..s177, s178..s288)
//   T*_ constants               - 1-based tap positions of the round function
//   trivium_fsm_e               - controller state encoding
//   is_legal_width()            - accepted keystream widths per clock
// ---------------------------------------------------------------------------
package trivium_pkg;

    localparam int STATE_LEN     = 288;
    localparam int WARMUP_ROUNDS = 1152;
    localparam int KEY_LEN       = 80;
    localparam int IV_LEN        = 80;

    // Register bounds, 1-based: A = s1..s93, B = s94..s177, C = s178..s288
    localparam int REG_A_END = 93;
    localparam int REG_B_END = 177;
    localparam int REG_C_END = 288;

    // 0-based bit position where the IV starts (s94)
    localparam int IV_BASE = REG_A_END;

    // Output taps of each register (1-based)
    localparam int T1_OUT_A = 66;
    localparam int T1_OUT_B = 93;
    localparam int T2_OUT_A = 162;
    localparam int T2_OUT_B = 177;
    localparam int T3_OUT_A = 243;
    localparam int T3_OUT_B = 288;

    // Nonlinear AND taps and cross-register feed taps (1-based)
    localparam int T1_AND_A = 91;
    localparam int T1_AND_B = 92;
    localparam int T1_FEED  = 171;
    localparam int T2_AND_A = 175;
    localparam int T2_AND_B = 176;
    localparam int T2_FEED  = 264;
    localparam int T3_AND_A = 286;
    localparam int T3_AND_B = 287;
    localparam int T3_FEED  = 69;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } trivium_fsm_e;

    // Widths must divide the warm-up round count evenly
    function automatic bit is_legal_width(input int w);
        return (w == 1) || (w == 2) || (w == 4) || (w == 8) ||
               (w == 16) || (w == 32) || (w == 64);
    endfunction

endpackage

// File: rtl/trivium_stream_core_round.sv
// ---------------------------------------------------------------------------
// trivium_round
//
// One purely combinational Trivium round. The core chains W of these to
// produce W keystream bits per clock.
//
// Ports:
//   cur_state  [287:0]  state before the round, bit i-1 holds s_i
//   next_state [287:0]  state after the round
//   z                   keystream bit produced from cur_state
// ---------------------------------------------------------------------------
module trivium_round
    import trivium_pkg::*;
(
    input  logic [STATE_LEN-1:0] cur_state,
    output logic [STATE_LEN-1:0] next_state,
    output logic                 z
);

    logic t1_lin;
    logic t2_lin;
    logic t3_lin;
    logic t1_fb;
    logic t2_fb;
    logic t3_fb;

    // The keystream bit uses only the linear taps; the feedback words add
    // the AND term and a tap from a neighbouring register before being
    // shifted into the head of the next register.
    always_comb begin
        t1_lin = cur_state[T1_OUT_A-1] ^ cur_state[T1_OUT_B-1];
        t2_lin = cur_state[T2_OUT_A-1] ^ cur_state[T2_OUT_B-1];
        t3_lin = cur_state[T3_OUT_A-1] ^ cur_state[T3_OUT_B-1];

        z = t1_lin ^ t2_lin ^ t3_lin;

        t1_fb = t1_lin ^ (cur_state[T1_AND_A-1] & cur_state[T1_AND_B-1]) ^ cur_state[T1_FEED-1];
        t2_fb = t2_lin ^ (cur_state[T2_AND_A-1] & cur_state[T2_AND_B-1]) ^ cur_state[T2_FEED-1];
        t3_fb = t3_lin ^ (cur_state[T3_AND_A-1] & cur_state[T3_AND_B-1]) ^ cur_state[T3_FEED-1];

        // Each register shifts up by one; the last bit of each register is
        // dropped and the feedback from the previous register enters its head.
        next_state = {cur_state[REG_C_END-2:REG_B_END], t2_fb,
                      cur_state[REG_B_END-2:REG_A_END], t1_fb,
                      cur_state[REG_A_END-2:0],         t3_fb};
    end

endmodule

// File: rtl/trivium_stream_core.sv
// ---------------------------------------------------------------------------
// trivium_stream_core
//
// Trivium stream cipher producing W keystream bits per clock. The host loads
// key and IV with an init pulse, the core runs the 1152-round warm-up on its
// own and then XORs each accepted W-bit data word with fresh keystream into a
// registered output stage with a valid/ready handshake.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   key_i[79:0]           key, key_i[i-1] -> s_i
//   iv_i[79:0]            IV,  iv_i[i-1]  -> s_(93+i)
//   init_i                (re)start pulse, key/IV sampled on the same edge
//   busy_o                high during warm-up
//   dat_valid_i/ready_o   input word handshake
//   dat_i[W-1:0]          input word, bit 0 meets the earliest keystream bit
//   out_valid_o/ready_i   output word handshake
//   dat_o[W-1:0]          dat_i XOR keystream
// ---------------------------------------------------------------------------
module trivium_stream_core
    import trivium_pkg::*;
#(
    parameter int W = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [79:0]   key_i,
    input  logic [79:0]   iv_i,
    input  logic          init_i,
    output logic          busy_o,
    input  logic          dat_valid_i,
    output logic          dat_ready_o,
    input  logic [W-1:0]  dat_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [W-1:0]  dat_o
);

    localparam int WARM_CYCLES = WARMUP_ROUNDS / W;
    localparam int CNT_W       = $clog2(WARM_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARM_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WARM_CYCLES);

    if (!is_legal_width(W)) begin : g_width_check
        $error("trivium_stream_core: W=%0d must be one of 1,2,4,8,16,32,64", W);
    end

    trivium_fsm_e          fsm_q;
    logic [STATE_LEN-1:0]  state_q;
    logic [STATE_LEN-1:0]  load_state;
    logic [STATE_LEN-1:0]  adv_state;
    logic [CNT_W-1:0]      warm_cnt;
    logic [W-1:0]          ks;
    logic                  busy_q;
    logic                  out_valid_q;
    logic [W-1:0]          dat_q;
    logic                  accept;

    // Fresh state for an init pulse: key in register A, IV in register B,
    // the three top bits of register C set, everything else cleared.
    always_comb begin
        load_state                        = '0;
        load_state[KEY_LEN-1:0]           = key_i;
        load_state[IV_BASE +: IV_LEN]     = iv_i;
        load_state[STATE_LEN-1 -: 3]      = 3'b111;
    end

    // W rounds chained combinationally. Stage k sees the state after k
    // rounds, so ks[k] is keystream bit z_(k+1) of this word.
    for (genvar k = 0; k < W; k++) begin : g_round
        logic [STATE_LEN-1:0] stage_in;
        logic [STATE_LEN-1:0] stage_out;

        if (k == 0) begin : g_first
            assign stage_in = state_q;
        end else begin : g_next
            assign stage_in = g_round[k-1].stage_out;
        end

        trivium_round u_round (
            .cur_state  (stage_in),
            .next_state (stage_out),
            .z          (ks[k])
        );
    end

    assign adv_state = g_round[W-1].stage_out;

    // A new word may enter only in RUN, never on an init edge, and only when
    // the output register is empty or is being drained on this same edge.
    assign dat_ready_o = (fsm_q == ST_RUN) && !init_i && (!out_valid_q || out_ready_i);
    assign accept      = dat_valid_i && dat_ready_o;

    assign busy_o      = busy_q;
    assign out_valid_o = out_valid_q;
    assign dat_o       = dat_q;

    // Controller, cipher state, warm-up counter and output register.
    // init_i overrides every state and drops any word waiting at the output.
    // The cipher state only advances during warm-up or on an accepted beat,
    // so stalls on either side never consume keystream.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q       <= ST_IDLE;
            state_q     <= '0;
            warm_cnt    <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            dat_q       <= '0;
        end else if (init_i) begin
            fsm_q       <= ST_WARMUP;
            state_q     <= load_state;
            warm_cnt    <= '0;
            busy_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                end

                ST_WARMUP: begin
                    state_q <= adv_state;
                    if (warm_cnt == CNT_LAST) begin
                        warm_cnt <= CNT_DONE;
                        fsm_q    <= ST_RUN;
                        busy_q   <= 1'b0;
                    end else begin
                        warm_cnt <= warm_cnt + 1'b1;
                    end
                end

                ST_RUN: begin
                    if (accept) begin
                        state_q     <= adv_state;
                        dat_q       <= dat_i ^ ks;
                        out_valid_q <= 1'b1;
                    end else if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                    end
                end

                default: begin
                    fsm_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
